// File: rtl/calc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : calc_pkg                                                    |
// | Brief    : Shared opcodes, error codes, FSM state encoding and default |
// |            widths for the calculator issue controller.                 |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package calc_pkg;

  // Default widths matching the combinational calculator ALU
  localparam int CALC_DATA_W = 4;
  localparam int CALC_OP_W   = 3;
  localparam int CALC_RES_W  = 8;

  // ALU opcodes; codes 110 and 111 are illegal
  localparam logic [CALC_OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [CALC_OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [CALC_OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [CALC_OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [CALC_OP_W-1:0] OP_MOD = 3'b100;
  localparam logic [CALC_OP_W-1:0] OP_NOT = 3'b101;

  // Status codes reported alongside each result
  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL_OP = 2'b01;
  localparam logic [1:0] ERR_DIV_ZERO   = 2'b10;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } calc_state_t;

  // Classify a command before it may reach the ALU
  function automatic logic [1:0] calc_classify(input logic [CALC_OP_W-1:0] op,
                                               input logic                 b_is_zero);
    logic [1:0] code;
    code = ERR_NONE;
    if (op > OP_NOT) begin
      code = ERR_ILLEGAL_OP;
    end else if (((op == OP_DIV) || (op == OP_MOD)) && b_is_zero) begin
      code = ERR_DIV_ZERO;
    end
    return code;
  endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_issue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : calc_issue_ctrl                                             |
// | Brief    : Valid/ready front-end for the combinational calculator ALU. |
// |            Screens illegal opcodes and divide/modulo by zero, drives   |
// |            registered operands, waits SETTLE_CYC cycles, captures the  |
// |            ALU result and offers it on a valid/ready output.           |
// |            Optional: CALC_OP_COUNT_EN adds op_count, a wrapping count  |
// |            of successful result handshakes.                            |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module calc_issue_ctrl
  import calc_pkg::*;
#(
  parameter int DATA_W     = CALC_DATA_W,
  parameter int OP_W       = CALC_OP_W,
  parameter int RES_W      = CALC_RES_W,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // Command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  // ALU side
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_oper,
  input  logic [RES_W-1:0]  alu_out,
  // Result side
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_err,
`ifdef CALC_OP_COUNT_EN
  output logic [CNT_W-1:0]  op_count,
`endif
  output logic [1:0]        res_err_code
);

  // Settle counter is sized for the full legal SETTLE_CYC range 1..15
  localparam int             c_SET_W       = 4;
  localparam logic [c_SET_W-1:0] c_SET_LOAD = c_SET_W'(SETTLE_CYC - 1);

  calc_state_t          r_state;
  logic [c_SET_W-1:0]   r_settle;
  logic [1:0]           w_err_code;
  logic                 w_b_zero;

  assign w_b_zero   = (cmd_b == '0);
  assign w_err_code = calc_classify(cmd_op, w_b_zero);

  // Handshake flags decode straight from the state register
  assign cmd_ready = (r_state == IDLE);
  assign res_valid = (r_state == DONE);

  // Main FSM: accept and screen commands, time the ALU settle, hold the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_settle     <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_oper     <= '0;
      res_data     <= '0;
      res_err      <= 1'b0;
      res_err_code <= ERR_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            if (w_err_code != ERR_NONE) begin
              // Rejected commands leave the ALU inputs on the last legal command
              res_data     <= '0;
              res_err      <= 1'b1;
              res_err_code <= w_err_code;
              r_state      <= DONE;
            end else begin
              alu_a    <= cmd_a;
              alu_b    <= cmd_b;
              alu_oper <= cmd_op;
              r_settle <= c_SET_LOAD;
              r_state  <= EXEC;
            end
          end
        end
        EXEC: begin
          if (r_settle == '0) begin
            res_data     <= alu_out;
            res_err      <= 1'b0;
            res_err_code <= ERR_NONE;
            r_state      <= DONE;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef CALC_OP_COUNT_EN
  logic [CNT_W-1:0] r_op_count;

  // Count successful result handshakes; wraps naturally at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if ((r_state == DONE) && res_ready && !res_err) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule : calc_issue_ctrl
`default_nettype wire

// File: tb/tb_calc_issue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_calc_issue_ctrl                                          |
// | Brief    : Self-checking bench for calc_issue_ctrl with a behavioural  |
// |            calculator model beside each instance and a result          |
// |            scoreboard. CALC_OP_COUNT_EN enables op_count checks.       |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_calc_issue_ctrl;

  localparam int SETTLE_A = 1;
  localparam int SETTLE_B = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
    logic [1:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_a = '0;
  logic [3:0] cmd_b = '0;
  logic [2:0] cmd_op = '0;
  logic       res_ready = 1'b0;

  logic       cmd_ready, res_valid, res_err;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_oper;
  logic [7:0] alu_out, res_data;
  logic [1:0] res_err_code;

  logic       cmd_ready_3, res_valid_3, res_err_3;
  logic [3:0] alu_a_3, alu_b_3;
  logic [2:0] alu_oper_3;
  logic [7:0] alu_out_3, res_data_3;
  logic [1:0] res_err_code_3;
`ifdef CALC_OP_COUNT_EN
  logic [15:0] op_count, op_count_3;
`endif

  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  exp_t sb_q[$];
  int   t_q[$];
  int   lat_q[$];
  logic [3:0] m_alu_a = '0;
  logic [3:0] m_alu_b = '0;
  logic [2:0] m_alu_oper = '0;

  // Behavioural calculator ALU
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op);
    logic [7:0] ea, eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (op)
      3'd0: return ea + eb;
      3'd1: return ea - eb;
      3'd2: return ea * eb;
      3'd3: return (b == 0) ? 8'h00 : ea / eb;
      3'd4: return (b == 0) ? 8'h00 : ea % eb;
      3'd5: return {4'b0, ~a};
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_out   = alu_f(alu_a, alu_b, alu_oper);
  always_comb alu_out_3 = alu_f(alu_a_3, alu_b_3, alu_oper_3);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_issue_ctrl #(.DATA_W(4), .OP_W(3), .RES_W(8), .SETTLE_CYC(SETTLE_A), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err),
`ifdef CALC_OP_COUNT_EN
    .op_count(op_count),
`endif
    .res_err_code(res_err_code)
  );

  calc_issue_ctrl #(.DATA_W(4), .OP_W(3), .RES_W(8), .SETTLE_CYC(SETTLE_B), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_3),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_oper(alu_oper_3), .alu_out(alu_out_3),
    .res_valid(res_valid_3), .res_ready(res_ready), .res_data(res_data_3),
    .res_err(res_err_3),
`ifdef CALC_OP_COUNT_EN
    .op_count(op_count_3),
`endif
    .res_err_code(res_err_code_3)
  );

  // Assert reset for two cycles and release on a falling edge
  task automatic do_reset();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete(); t_q.delete(); lat_q.delete();
    m_alu_a = '0; m_alu_b = '0; m_alu_oper = '0;
  endtask

  // Called on a falling edge; drives one command and records its expected result
  task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    exp_t e;
    int   n;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      $display("FAIL send_cmd: cmd_ready stuck at %b, wanted 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    if (op >= 3'd6) e.code = 2'b01;
    else if ((op == 3'd3 || op == 3'd4) && b == 4'd0) e.code = 2'b10;
    else e.code = 2'b00;
    e.err  = (e.code != 2'b00);
    e.data = e.err ? 8'h00 : alu_f(a, b, op);
    if (!e.err) begin
      m_alu_a = a; m_alu_b = b; m_alu_oper = op;
    end
    sb_q.push_back(e);
    t_q.push_back(cyc);
    lat_q.push_back(e.err ? 1 : 1 + SETTLE_A);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for res_valid, pop the scoreboard and compare; does not acknowledge
  task automatic recv_result(input string name);
    int   n;
    exp_t e;
    int   t0, lat;
    n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!res_valid) begin
      $display("FAIL %s: res_valid never rose (got 0, want 1)", name);
      return;
    end
    if (sb_q.size() == 0) begin
      $display("FAIL %s: result with empty scoreboard, got data %h", name, res_data);
      return;
    end
    passed++;
    e = sb_q.pop_front(); t0 = t_q.pop_front(); lat = lat_q.pop_front();
    total++;
    if (res_data !== e.data) $display("FAIL %s res_data: got %h want %h", name, res_data, e.data);
    else passed++;
    total++;
    if (res_err !== e.err) $display("FAIL %s res_err: got %b want %b", name, res_err, e.err);
    else passed++;
    total++;
    if (res_err_code !== e.code) $display("FAIL %s res_err_code: got %b want %b", name, res_err_code, e.code);
    else passed++;
    total++;
    if (cyc - t0 !== lat) $display("FAIL %s latency: got %0d want %0d", name, cyc - t0, lat);
    else passed++;
    total++;
    if ({alu_a, alu_b, alu_oper} !== {m_alu_a, m_alu_b, m_alu_oper})
      $display("FAIL %s alu_regs: got %h/%h/%b want %h/%h/%b", name, alu_a, alu_b, alu_oper,
               m_alu_a, m_alu_b, m_alu_oper);
    else passed++;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({alu_a, alu_b, alu_oper, res_data, res_err, res_err_code, res_valid} !== '0)
      $display("FAIL reset_outputs: got %h/%h/%b/%h/%b/%b/%b want all zero", alu_a, alu_b,
               alu_oper, res_data, res_err, res_err_code, res_valid);
    else passed++;
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL reset_idle: got ready=%b valid=%b want 1/0", cmd_ready, res_valid);
    else passed++;
  endtask

  task automatic test_add();
    send_cmd(4'd3, 4'd5, 3'b000);
    recv_result("add");
    total++;
    if (res_data !== 8'h08 || alu_a !== 4'd3 || alu_b !== 4'd5 || alu_oper !== 3'b000)
      $display("FAIL add_literal: got %h %h %h %b want 08 3 5 000", res_data, alu_a, alu_b, alu_oper);
    else passed++;
    ack();
  endtask

  task automatic test_sub_mul();
    send_cmd(4'd3, 4'd5, 3'b001);
    recv_result("sub_underflow");
    total++;
    if (res_data !== 8'hFE) $display("FAIL sub_literal: got %h want fe", res_data);
    else passed++;
    ack();
    send_cmd(4'd15, 4'd15, 3'b010);
    recv_result("mul_max");
    total++;
    if (res_data !== 8'hE1) $display("FAIL mul_literal: got %h want e1", res_data);
    else passed++;
    ack();
  endtask

  task automatic test_div_zero();
    send_cmd(4'd9, 4'd0, 3'b011);
    recv_result("div_zero");
    total++;
    if (alu_a !== 4'd15 || alu_b !== 4'd15 || alu_oper !== 3'b010)
      $display("FAIL div_zero_alu_hold: got %h %h %b want f f 010", alu_a, alu_b, alu_oper);
    else passed++;
    ack();
    send_cmd(4'd9, 4'd0, 3'b100);
    recv_result("mod_zero");
    ack();
  endtask

  task automatic test_illegal();
    send_cmd(4'd1, 4'd1, 3'b110);
    recv_result("illegal_110");
    ack();
    send_cmd(4'd1, 4'd1, 3'b111);
    recv_result("illegal_111");
    ack();
    send_cmd(4'd9, 4'd2, 3'b011);
    recv_result("div_after_illegal");
    total++;
    if (res_data !== 8'h04) $display("FAIL div_literal: got %h want 04", res_data);
    else passed++;
    ack();
  endtask

  task automatic test_backpressure();
    send_cmd(4'd7, 4'd2, 3'b100);
    recv_result("bp_mod");
    // Queue the next command while the result is held
    cmd_valid = 1'b1; cmd_a = 4'd5; cmd_b = 4'd6; cmd_op = 3'b000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || res_data !== 8'h01 || res_err !== 1'b0 || cmd_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h err=%b ready=%b want 1 01 0 0", i,
                 res_valid, res_data, res_err, cmd_ready);
      else passed++;
    end
    ack();
    total++;
    if (cmd_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", cmd_ready);
    else passed++;
    send_cmd(4'd5, 4'd6, 3'b000);
    recv_result("bp_queued");
    ack();
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      send_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      recv_result("random");
      ack();
    end
  endtask

`ifdef CALC_OP_COUNT_EN
  task automatic test_op_count();
    do_reset();
    total++;
    if (op_count !== 16'd0) $display("FAIL op_count_reset: got %0d want 0", op_count);
    else passed++;
    send_cmd(4'd1, 4'd2, 3'b000); recv_result("cnt_a"); ack();
    send_cmd(4'd1, 4'd1, 3'b110); recv_result("cnt_bad"); ack();
    send_cmd(4'd8, 4'd2, 3'b011); recv_result("cnt_b"); ack();
    send_cmd(4'd4, 4'd3, 3'b010); recv_result("cnt_c"); ack();
    total++;
    if (op_count !== 16'd3) $display("FAIL op_count_total: got %0d want 3", op_count);
    else passed++;
  endtask
`endif

  task automatic test_reset_mid_exec();
    int t0, n;
    do_reset();
    send_cmd(4'd2, 4'd3, 3'b000);
    total++;
    if (cmd_ready_3 !== 1'b0 || res_valid_3 !== 1'b0 || alu_a_3 !== 4'd2)
      $display("FAIL pre_reset_exec: got ready=%b valid=%b alu_a=%h want 0 0 2",
               cmd_ready_3, res_valid_3, alu_a_3);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({alu_a_3, alu_b_3, alu_oper_3, res_data_3, res_err_3, res_err_code_3, res_valid_3} !== '0
        || cmd_ready_3 !== 1'b1)
      $display("FAIL async_reset: got %h/%h/%b/%h ready=%b want zeros ready=1",
               alu_a_3, alu_b_3, alu_oper_3, res_data_3, cmd_ready_3);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete(); t_q.delete(); lat_q.delete();
    @(negedge clk);
    total++;
    if (cmd_ready_3 !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", cmd_ready_3);
    else passed++;
    // Latency through the slower instance
    cmd_valid = 1'b1; cmd_a = 4'd4; cmd_b = 4'd6; cmd_op = 3'b010;
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid_3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!res_valid_3 || cyc - t0 !== 1 + SETTLE_B || res_data_3 !== 8'h18 || alu_a_3 !== 4'd4)
      $display("FAIL settle3: got valid=%b lat=%0d data=%h alu_a=%h want 1 %0d 18 4",
               res_valid_3, cyc - t0, res_data_3, alu_a_3, 1 + SETTLE_B);
    else passed++;
    ack();
    sb_q.delete(); t_q.delete(); lat_q.delete();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mul();
    test_div_zero();
    test_illegal();
    test_backpressure();
    test_random();
`ifdef CALC_OP_COUNT_EN
    test_op_count();
`endif
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_calc_issue_ctrl
`default_nettype wire
